// File: rtl/tristate_bus_arbiter_if.sv
// Handshake and bus signals between the arbiter and its four agents.
// master: arbiter side. slave: agent/bus side.
interface tristate_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [7:0] bus_in;
  logic [3:0] en;
  logic [1:0] owner;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       timeout;

  modport master (
    input  req, done, bus_in,
    output en, owner, busy,
    output rx_data, rx_valid, timeout
  );

  modport slave (
    output req, done, bus_in,
    input  en, owner, busy,
    input  rx_data, rx_valid, timeout
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving one-hot tristate enables for four agents.
// Define TRISTATE_TURNAROUND_EN to insert a bus-park cycle between owners.
module tristate_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  tristate_bus_arbiter_if.master bus
);

`ifdef TRISTATE_TURNAROUND_EN
  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    GRANT
  } state_t;
`endif

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] last_owner;

  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       hit;
  logic       own_done;
  logic       own_req;
  logic       expire;
  logic       rel;

  // In GRANT the search starts after the current owner so a
  // zero-gap handover already sees the updated round-robin base.
  always_comb begin
    base = (state == GRANT) ? bus.owner : last_owner;
    hit  = 1'b0;
    pick = base;
    cand = base;
    for (int i = 1; i <= 4; i++) begin
      cand = base + 2'(i);
      if (!hit && bus.req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  assign own_done = bus.done[bus.owner];
  assign own_req  = bus.req[bus.owner];
  assign expire   = (cnt == CNT_MAX);
  assign rel      = own_done | ~own_req | expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.en      <= 4'b0000;
      bus.busy    <= 1'b0;
      bus.owner   <= 2'd0;
      bus.rx_data <= 8'h00;
      bus.rx_valid <= 1'b0;
      bus.timeout <= 1'b0;
      cnt         <= 8'd0;
      last_owner  <= 2'd3;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.timeout  <= 1'b0;
      unique case (state)
        GRANT: begin
          if (rel) begin
            last_owner <= bus.owner;
            if (own_done) begin
              bus.rx_data  <= bus.bus_in;
              bus.rx_valid <= 1'b1;
            end else if (expire) begin
              bus.timeout <= 1'b1;
            end
`ifdef TRISTATE_TURNAROUND_EN
            state    <= TURN;
            bus.en   <= 4'b0000;
            bus.busy <= 1'b0;
`else
            if (hit) begin
              state     <= GRANT;
              bus.en    <= 4'b0001 << pick;
              bus.owner <= pick;
              bus.busy  <= 1'b1;
              cnt       <= 8'd0;
            end else begin
              state    <= IDLE;
              bus.en   <= 4'b0000;
              bus.busy <= 1'b0;
            end
`endif
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (hit) begin
            state     <= GRANT;
            bus.en    <= 4'b0001 << pick;
            bus.owner <= pick;
            bus.busy  <= 1'b1;
            cnt       <= 8'd0;
          end else begin
            state    <= IDLE;
            bus.en   <= 4'b0000;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
